// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limit, controller states and digit helpers
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic bcd_digit_t nines_comp(bcd_digit_t d);
    return BCD_MAX - d;
  endfunction
  function automatic logic digit_valid(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_addsub_seq_if.sv
// bcd_addsub_seq_if: operand request (in_valid/in_ready/op_sub/a/b/cin) and result (out_valid/out_ready/sum/cout/err) handshakes
interface bcd_addsub_seq_if #(parameter int NDIG = 8);
  logic in_valid, in_ready, op_sub, cin;
  logic out_valid, out_ready, cout, err;
  logic [4*NDIG-1:0] a, b, sum;
  modport master(output in_valid, op_sub, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, err);
  modport slave(input in_valid, op_sub, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, err);
endinterface

// File: rtl/bcd_byte_add.sv
// bcd_byte_add: combinational two-digit BCD add, a/b byte + ci -> corrected byte s and decimal carry co
module bcd_byte_add (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [4:0] t0, t1;
  logic c0;
  always_comb begin
    t0 = 5'(a[3:0]) + 5'(b[3:0]) + 5'(ci);
    c0 = t0 > 5'd9;
    s[3:0] = c0 ? 4'(t0 - 5'd10) : t0[3:0];
    t1 = 5'(a[7:4]) + 5'(b[7:4]) + 5'(c0);
    co = t1 > 5'd9;
    s[7:4] = co ? 4'(t1 - 5'd10) : t1[3:0];
  end
endmodule

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: byte-serial packed-BCD add/sub; clk, rst (sync high), bus = operand and result handshakes
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 8,
  localparam int CNT_W = $clog2(NDIG/2) + 1
) (
  input logic clk,
  input logic rst,
  bcd_addsub_seq_if.slave bus
);
  localparam int NB = NDIG / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] idx;
  logic [4*NDIG-1:0] a_r, b_r, b_lat, sum_r;
  logic carry, err_r, bad, co;
  logic [7:0] s_byte;
  always_comb begin
    b_lat = '0;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      b_lat[4*i +: 4] = bus.op_sub ? nines_comp(bus.b[4*i +: 4]) : bus.b[4*i +: 4];
      if (!digit_valid(bus.a[4*i +: 4]) || !digit_valid(bus.b[4*i +: 4])) bad = 1'b1;
    end
  end
  bcd_byte_add u_add (.a(a_r[8*idx +: 8]), .b(b_r[8*idx +: 8]), .ci(carry), .s(s_byte), .co(co));
  always_comb begin
    state_n = (state == IDLE && bus.in_valid) ? RUN :
              (state == RUN && idx == LAST) ? DONE :
              (state == DONE && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      err_r <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      idx <= '0;
      a_r <= bus.a;
      b_r <= b_lat;
      carry <= bus.op_sub ? !bus.cin : bus.cin;
      err_r <= bad;
    end else if (state == RUN) begin
      sum_r[8*idx +: 8] <= s_byte;
      carry <= co;
      idx <= idx + 1'b1;
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.sum = err_r ? '0 : sum_r;
  assign bus.cout = err_r ? 1'b0 : carry;
  assign bus.err = err_r;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb_bcd_addsub_seq: vector table, scoreboard queue and corner sequences for bcd_addsub_seq
module tb_bcd_addsub_seq;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  bcd_addsub_seq_if #(.NDIG(8)) bus ();
  bcd_addsub_seq #(.NDIG(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic op_sub; logic [31:0] a, b; logic cin; logic [31:0] sum; logic cout, err;} vec_t;
  typedef struct {logic [31:0] sum; logic cout, err;} exp_t;
  exp_t exp_q[$];
  vec_t vecs[11];
  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic vec_t model(input logic op, input int va, input int vb, input logic c);
    vec_t v;
    longint r;
    v.op_sub = op; v.a = to_bcd(va); v.b = to_bcd(vb); v.cin = c; v.err = 0;
    r = op ? longint'(va) - vb - c : longint'(va) + vb + c;
    v.cout = op ? (r >= 0) : (r >= 100000000);
    if (r < 0) r += 100000000;
    v.sum = to_bcd(int'(r % 100000000));
    return v;
  endfunction
  task automatic run_op(input vec_t v, input int hold);
    int n, lat;
    exp_t e;
    logic [31:0] s0;
    logic c0;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1; bus.op_sub = v.op_sub; bus.a = v.a; bus.b = v.b; bus.cin = v.cin;
    @(posedge clk);
    exp_q.push_back('{v.sum, v.cout, v.err});
    #1;
    bus.in_valid = 0; bus.a = $urandom; bus.b = $urandom; bus.op_sub = !v.op_sub; bus.cin = !v.cin;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!bus.out_valid && lat < 20);
    check("latency", 32'(lat), 32'd4);
    s0 = bus.sum; c0 = bus.cout;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0]; bus.a = 32'h1111_1111;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_sum_stable", bus.sum, s0);
      check("bp_cout_stable", 32'(bus.cout), 32'(c0));
    end
    bus.in_valid = 0;
    if (exp_q.size() == 0) check("queue_nonempty", 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      check("sum", bus.sum, e.sum);
      check("cout", 32'(bus.cout), 32'(e.cout));
      check("err", 32'(bus.err), 32'(e.err));
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    vecs[0]  = '{0, 32'h12345678, 32'h87654321, 0, 32'h99999999, 0, 0};
    vecs[1]  = '{0, 32'h99999999, 32'h00000001, 0, 32'h00000000, 1, 0};
    vecs[2]  = '{0, 32'h00000009, 32'h00000001, 1, 32'h00000011, 0, 0};
    vecs[3]  = '{1, 32'h00005000, 32'h00001234, 0, 32'h00003766, 1, 0};
    vecs[4]  = '{1, 32'h00001234, 32'h00005000, 0, 32'h99996234, 0, 0};
    vecs[5]  = '{0, 32'h0000A123, 32'h00000001, 0, 32'h00000000, 0, 1};
    vecs[6]  = '{0, 32'h00000001, 32'h00000001, 0, 32'h00000002, 0, 0};
    vecs[7]  = '{1, 32'h00005000, 32'h00001234, 1, 32'h00003765, 1, 0};
    vecs[8]  = '{1, 32'h12345678, 32'h12345678, 0, 32'h00000000, 1, 0};
    vecs[9]  = '{0, 32'h50000000, 32'h50000000, 1, 32'h00000001, 1, 0};
    vecs[10] = '{0, 32'h00000001, 32'h0000000F, 0, 32'h00000000, 0, 1};
    bus.in_valid = 0; bus.out_ready = 0; bus.op_sub = 0; bus.a = 0; bus.b = 0; bus.cin = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", bus.sum, 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 0;
    foreach (vecs[i]) run_op(vecs[i], 0);
    run_op(vecs[3], 6);
    @(negedge clk);
    bus.in_valid = 1; bus.op_sub = 0; bus.a = 32'h99999999; bus.b = 32'h99999999; bus.cin = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum", bus.sum, 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    run_op(vecs[0], 0);
    for (int i = 0; i < 8; i++)
      run_op(model(1'($urandom_range(0, 1)), int'($urandom_range(0, 99999999)),
                   int'($urandom_range(0, 99999999)), 1'($urandom_range(0, 1))), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
